// File: rtl/z80_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | z80_pkg : shared constants and types for the Z80 bus tracer          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package z80_pkg;

  // Bus-cycle type codes; bit 1 = I/O space, bit 0 = write.
  localparam logic [1:0] MEM_RD = 2'b00;
  localparam logic [1:0] MEM_WR = 2'b01;
  localparam logic [1:0] IO_RD  = 2'b10;
  localparam logic [1:0] IO_WR  = 2'b11;

  localparam int TRACE_W = 26;

  typedef enum logic [1:0] {
    DISARMED  = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } tracer_state_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_fifo : first-word-fall-through FIFO with sticky overflow flag  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 26
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign w_do_pop  = pop & ~w_empty & ~clear;
  assign w_do_push = push & (~w_full | w_do_pop) & ~clear;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (push && !w_do_push) r_overflow <= 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/z80_bus_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | z80_bus_tracer : captures Z80 bus cycles into a trace FIFO with      |
// |                  address breakpoints and a halt request              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module z80_bus_tracer
  import z80_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int NUM_BP      = 2,
  parameter int STOP_ON_HIT = 1
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [15:0]                               address,
  input  logic [7:0]                                dbus_in,
  input  logic [7:0]                                dbus_out,
  input  logic                                      rd_n,
  input  logic                                      wr_n,
  input  logic                                      mreq_n,
  input  logic                                      iorq_n,
  input  logic                                      trace_en,
  input  logic                                      clear,
  input  logic [16*NUM_BP-1:0]                      bp_addr,
  input  logic [NUM_BP-1:0]                         bp_en,
  input  logic                                      pop,
  output logic [TRACE_W-1:0]                        tr_data,
  output logic                                      tr_empty,
  output logic                                      tr_full,
  output logic [$clog2(DEPTH):0]                    tr_count,
  output logic                                      overflow,
  output logic                                      hit,
  output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] hit_index,
  output logic                                      halt_req
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  // Two-stage bus pipeline: stage 1 samples the pins, stage 2 holds the last in-cycle values.
  logic [15:0] r_addr,   r_addr_d;
  logic [7:0]  r_din,    r_din_d;
  logic [7:0]  r_dout,   r_dout_d;
  logic        r_rd_n,   r_wr_n,   r_mreq_n,   r_iorq_n;
  logic        r_wr_n_d, r_mreq_n_d, r_iorq_n_d;
  logic        r_strobe_d;
  logic        r_vld, r_vld_d;
  logic        r_in_cycle;

  logic              w_strobe, w_fall, w_rise, w_cap;
  logic [1:0]        w_type;
  logic [TRACE_W-1:0] w_entry;

  assign w_strobe = r_rd_n & r_wr_n;
  // A fall counts only if both samples came from the live bus, which discards cycles cut by reset.
  assign w_fall   = r_vld_d & r_strobe_d & ~w_strobe;
  assign w_rise   = ~r_strobe_d & w_strobe;
  assign w_cap    = w_rise & r_in_cycle & ~(r_mreq_n_d & r_iorq_n_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;  r_din    <= '0;  r_dout   <= '0;
      r_rd_n     <= 1'b1; r_wr_n  <= 1'b1; r_mreq_n <= 1'b1; r_iorq_n <= 1'b1;
      r_addr_d   <= '0;  r_din_d  <= '0;  r_dout_d <= '0;
      r_wr_n_d   <= 1'b1; r_mreq_n_d <= 1'b1; r_iorq_n_d <= 1'b1;
      r_strobe_d <= 1'b1;
      r_vld      <= 1'b0;
      r_vld_d    <= 1'b0;
      r_in_cycle <= 1'b0;
    end else begin
      r_addr     <= address;  r_din   <= dbus_in; r_dout   <= dbus_out;
      r_rd_n     <= rd_n;     r_wr_n  <= wr_n;    r_mreq_n <= mreq_n; r_iorq_n <= iorq_n;
      r_addr_d   <= r_addr;   r_din_d <= r_din;   r_dout_d <= r_dout;
      r_wr_n_d   <= r_wr_n;   r_mreq_n_d <= r_mreq_n; r_iorq_n_d <= r_iorq_n;
      r_strobe_d <= w_strobe;
      r_vld      <= 1'b1;
      r_vld_d    <= r_vld;
      if (w_fall)      r_in_cycle <= 1'b1;
      else if (w_rise) r_in_cycle <= 1'b0;
    end
  end

  always_comb begin
    w_type = MEM_RD;
    if (!r_iorq_n_d) w_type = r_wr_n_d ? IO_RD  : IO_WR;
    else             w_type = r_wr_n_d ? MEM_RD : MEM_WR;
  end

  assign w_entry = {w_type, r_addr_d, (r_wr_n_d ? r_din_d : r_dout_d)};

  logic             w_bp_match;
  logic [IDX_W-1:0] w_bp_idx;

  // Scan downwards so the lowest matching comparator is the one left standing.
  always_comb begin
    w_bp_match = 1'b0;
    w_bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[16*i +: 16] == r_addr_d)) begin
        w_bp_match = 1'b1;
        w_bp_idx   = IDX_W'(i);
      end
    end
  end

  tracer_state_t r_state, w_next;
  logic          w_push_ok, w_push, w_new_hit;

  assign w_push_ok = (r_state == ARMED) || ((r_state == TRIGGERED) && (STOP_ON_HIT == 0));
  assign w_push    = w_cap & w_push_ok;
  assign w_new_hit = w_cap & (r_state == ARMED) & w_bp_match;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= DISARMED;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = DISARMED;
    end else begin
      case (r_state)
        DISARMED:  if (trace_en) w_next = ARMED;
        ARMED: begin
          if (w_new_hit)     w_next = TRIGGERED;
          else if (!trace_en) w_next = DISARMED;
        end
        TRIGGERED: w_next = TRIGGERED;
        default:   w_next = DISARMED;
      endcase
    end
  end

  logic             r_hit;
  logic [IDX_W-1:0] r_hit_index;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit       <= 1'b0;
      r_hit_index <= '0;
    end else if (clear) begin
      r_hit       <= 1'b0;
      r_hit_index <= '0;
    end else if (w_new_hit && !r_hit) begin
      r_hit       <= 1'b1;
      r_hit_index <= w_bp_idx;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TRACE_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .push     (w_push),
    .din      (w_entry),
    .pop      (pop),
    .dout     (tr_data),
    .empty    (tr_empty),
    .full     (tr_full),
    .count    (tr_count),
    .overflow (overflow)
  );

  assign hit       = r_hit;
  assign hit_index = r_hit_index;
  assign halt_req  = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_z80_bus_tracer : randomized self-checking bench for the tracer    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_z80_bus_tracer;
  import z80_pkg::*;

  localparam int DEPTH  = 16;
  localparam int NUM_BP = 2;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] address  = '0;
  logic [7:0]  dbus_in  = '0;
  logic [7:0]  dbus_out = '0;
  logic        rd_n = 1'b1, wr_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic        trace_en = 1'b0, clear = 1'b0, pop = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [1:0]  bp_en   = '0;
  logic [25:0] tr_data;
  logic        tr_empty, tr_full, overflow, hit, halt_req;
  logic [4:0]  tr_count;
  logic [0:0]  hit_index;

  always #5 clk = ~clk;

  z80_bus_tracer #(.DEPTH(DEPTH), .NUM_BP(NUM_BP), .STOP_ON_HIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .rd_n(rd_n), .wr_n(wr_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .trace_en(trace_en), .clear(clear), .bp_addr(bp_addr), .bp_en(bp_en), .pop(pop),
    .tr_data(tr_data), .tr_empty(tr_empty), .tr_full(tr_full), .tr_count(tr_count),
    .overflow(overflow), .hit(hit), .hit_index(hit_index), .halt_req(halt_req)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of retained entries plus sticky flags.
  logic [25:0] mq [$];
  bit          m_ovf = 1'b0;
  bit          m_hit = 1'b0;
  int          m_idx = 0;
  int          r;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_val({tag, ":count"},    32'(tr_count), 32'(mq.size()));
    check_val({tag, ":empty"},    32'(tr_empty), 32'(mq.size() == 0));
    check_val({tag, ":full"},     32'(tr_full),  32'(mq.size() == DEPTH));
    check_val({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, ":hit"},      32'(hit),      32'(m_hit));
    check_val({tag, ":halt"},     32'(halt_req), 32'(m_hit));
    check_val({tag, ":hit_idx"},  32'(hit_index), m_hit ? 32'(m_idx) : 32'd0);
    check_val({tag, ":head"},     32'(tr_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
  endtask

  task automatic bus_cycle(input bit io, input bit wr, input logic [15:0] a,
                           input logic [7:0] d, input bit ign, input bit pop_at_push);
    @(negedge clk);
    address  = a;
    dbus_in  = wr ? 8'($urandom) : d;
    dbus_out = wr ? d : 8'($urandom);
    mreq_n   = ign | io;
    iorq_n   = ign | ~io;
    rd_n     = wr;
    wr_n     = ~wr;
    repeat ($urandom_range(1, 3)) @(negedge clk);
    // Bus lines change as the strobe rises; the capture must keep the in-cycle values.
    rd_n = 1'b1; wr_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    address = 16'($urandom); dbus_in = 8'($urandom); dbus_out = 8'($urandom);
    @(negedge clk);
    check_val("hit_latency", 32'(hit), 32'(m_hit));
    if (pop_at_push) begin
      if (mq.size() > 0) check_val("pop_head", 32'(tr_data), 32'(mq[0]));
      pop = 1'b1;
    end
    @(negedge clk);
    pop = 1'b0;
    if (pop_at_push && mq.size() > 0) void'(mq.pop_front());
    if (!ign && trace_en && !m_hit) begin
      if (mq.size() < DEPTH) mq.push_back({io, wr, a, d});
      else m_ovf = 1'b1;
      for (int i = 0; i < NUM_BP; i++) begin
        if (!m_hit && bp_en[i] && bp_addr[16*i +: 16] == a) begin
          m_hit = 1'b1;
          m_idx = i;
        end
      end
    end
  endtask

  task automatic do_pop(input string tag);
    @(negedge clk);
    check_val({tag, ":popped"}, 32'(tr_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_hit = 1'b0;
    m_idx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_state("reset");
    reset_n = 1'b1;
    @(negedge clk);
    trace_en = 1'b1;
    repeat (2) @(negedge clk);

    bus_cycle(1'b0, 1'b1, 16'h8000, 8'h55, 1'b0, 1'b0);
    check_state("memwr");
    check_val("memwr_entry", 32'(tr_data), 32'({MEM_WR, 16'h8000, 8'h55}));
    do_pop("p0");

    bus_cycle(1'b1, 1'b0, 16'h0010, 8'hA3, 1'b0, 1'b0);
    check_val("ioread_entry", 32'(tr_data), 32'({IO_RD, 16'h0010, 8'hA3}));
    do_pop("p1");
    check_val("empty_after_pop", 32'(tr_empty), 32'd1);

    do_pop("empty_pop");
    check_state("empty_pop");
    bus_cycle(1'b0, 1'b0, 16'h2222, 8'h77, 1'b0, 1'b1);
    check_state("pushpop_empty");
    bus_cycle(1'b0, 1'b0, 16'h3333, 8'h88, 1'b1, 1'b0);
    check_state("ignored");

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        trace_en = ($urandom_range(0, 7) != 0);
        bus_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                  8'($urandom), (r == 5), ($urandom_range(0, 3) == 0));
      end else begin
        do_pop("rand_pop");
      end
      check_state("rand");
    end
    trace_en = 1'b1;

    do_clear();
    for (int k = 0; k < 17; k++)
      bus_cycle(1'b0, 1'b0, 16'h1000 + 16'(k), 8'(k), 1'b0, 1'b0);
    check_state("full17");
    check_val("full17_oldest", 32'(tr_data), 32'({MEM_RD, 16'h1000, 8'h00}));
    check_val("full17_ovf", 32'(overflow), 32'd1);

    do_clear();
    for (int k = 0; k < 16; k++)
      bus_cycle(1'b0, 1'b0, 16'h5000 + 16'(k), 8'($urandom), 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b1, 16'h6000, 8'hC3, 1'b0, 1'b1);
    check_state("full_pushpop");
    check_val("full_pushpop_cnt", 32'(tr_count), 32'd16);
    check_val("full_pushpop_ovf", 32'(overflow), 32'd0);

    do_clear();
    bp_addr = {16'hFFFF, 16'h1234};
    bp_en   = 2'b10;
    bus_cycle(1'b0, 1'b0, 16'h1234, 8'h01, 1'b0, 1'b0);
    check_state("bp_disabled");
    bus_cycle(1'b0, 1'b0, 16'hFFFF, 8'h02, 1'b0, 1'b0);
    check_state("bp_hit");
    check_val("bp_hit_flag", 32'(hit), 32'd1);
    check_val("bp_hit_idx", 32'(hit_index), 32'd1);
    check_val("bp_halt", 32'(halt_req), 32'd1);
    bus_cycle(1'b0, 1'b1, 16'h0100, 8'h03, 1'b0, 1'b0);
    bus_cycle(1'b1, 1'b0, 16'h0200, 8'h04, 1'b0, 1'b0);
    check_state("after_hit");
    check_val("after_hit_cnt", 32'(tr_count), 32'd2);

    trace_en = 1'b0;
    do_clear();
    check_val("clear_hit", 32'(hit), 32'd0);
    bus_cycle(1'b0, 1'b0, 16'h0300, 8'h05, 1'b0, 1'b0);
    check_state("disarmed");

    trace_en = 1'b1;
    bp_addr  = {16'h1234, 16'h1234};
    bp_en    = 2'b11;
    repeat (2) @(negedge clk);
    bus_cycle(1'b1, 1'b1, 16'h1234, 8'h06, 1'b0, 1'b0);
    check_state("bp_lowest");
    check_val("bp_lowest_idx", 32'(hit_index), 32'd0);

    bp_en = 2'b00;
    @(negedge clk);
    address = 16'h4444; dbus_in = 8'h99; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    mq.delete(); m_ovf = 1'b0; m_hit = 1'b0; m_idx = 0;
    check_state("in_reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_n = 1'b1; mreq_n = 1'b1;
    repeat (3) @(negedge clk);
    check_state("post_reset");
    bus_cycle(1'b0, 1'b1, 16'hABCD, 8'hEF, 1'b0, 1'b0);
    check_state("post_reset_cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80_bus_tracer.md
Z80_BUS_TRACER -- requirements
Module: z80_bus_tracer

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, trace FIFO entries (power of 2, >=2).
REQ-002 SHALL provide parameter NUM_BP, default 2, address breakpoint comparators (1..8).
REQ-003 SHALL provide parameter STOP_ON_HIT, default 1, freeze capture after a breakpoint hit (0 = keep tracing).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  system clock; reset_n  in  1  async reset, active low.
REQ-005 address  in  16  Z80 address bus.
REQ-006 dbus_in  in  8  read data (to CPU); dbus_out  in  8  write data (from CPU).
REQ-007 rd_n, wr_n, mreq_n, iorq_n  in  1 each  Z80 strobes, active low.
REQ-008 trace_en  in  1  arm capture; clear  in  1  synchronous flush of FIFO, flags and state.
REQ-009 bp_addr  in  16*NUM_BP  breakpoint addresses, index 0 in bits 15:0; bp_en  in  NUM_BP  per-comparator enable.
REQ-010 pop  in  1  consume head entry; tr_data  out  26  head entry {type[1:0], addr[15:0], data[7:0]}; tr_empty  out  1; tr_full  out  1; tr_count  out  $clog2(DEPTH)+1.
REQ-011 overflow  out  1  sticky drop flag; hit  out  1  sticky breakpoint flag; hit_index  out  $clog2(NUM_BP) (min 1 bit)  matching comparator; halt_req  out  1  stop request to system.

Function
REQ-012 SHALL register all bus inputs every clk; a bus cycle completes when registered strobe (rd_n & wr_n) goes from 0 to 1.
REQ-013 On completion SHALL capture the previous-cycle registered address/data/type; type 00 mem read (data=dbus_in), 01 mem write (data=dbus_out), 10 io read, 11 io write.
REQ-014 Strobe completions with mreq_n and iorq_n both high SHALL be ignored.
REQ-015 FSM states DISARMED, ARMED, TRIGGERED; reset -> DISARMED.
REQ-016 DISARMED -> ARMED when trace_en=1; ARMED -> DISARMED when trace_en=0; ARMED -> TRIGGERED on breakpoint hit; TRIGGERED -> DISARMED only on clear.
REQ-017 Captures SHALL be pushed only in ARMED, or in TRIGGERED when STOP_ON_HIT=0; the hitting entry itself SHALL be pushed.
REQ-018 Breakpoint: captured address equal to bp_addr[i] with bp_en[i]=1; lowest matching i wins; hit and hit_index set in the cycle after capture.
REQ-019 halt_req SHALL equal hit (registered, asserted one cycle after capture) and hold until clear.
REQ-020 FIFO first-word-fall-through: tr_data valid whenever tr_empty=0; pop advances head next cycle.
REQ-021 Pop while empty SHALL be ignored; pointers wrap modulo DEPTH.
REQ-022 Push while full and no pop SHALL drop the entry and set overflow; push and pop same cycle when full SHALL both succeed, tr_count unchanged.
REQ-023 Push and pop same cycle when empty SHALL accept the push, ignore the pop.
REQ-024 clear SHALL take priority over push, pop and hit in the same cycle.

Reset
REQ-025 On reset_n low: FIFO empty, tr_count=0, tr_empty=1, tr_full=0, overflow=0, hit=0, hit_index=0, halt_req=0, tr_data=0, FSM DISARMED, bus registers all-ones strobes, zero data.
REQ-026 Reset mid-bus-cycle SHALL discard the partial cycle; no capture on the first strobe rise after release unless the fall was also observed after release.

Structure
REQ-027 Shared package z80_pkg SHALL hold bus-cycle type constants (MEM_RD, MEM_WR, IO_RD, IO_WR), trace entry width 26 and FSM state encodings.
REQ-028 FIFO storage and pointers SHALL be a sub-module trace_fifo parametrised by DEPTH and width.

Verification
REQ-029 Armed, mem write 0x55 to 0x8000 -> one entry {01,0x8000,0x55}, tr_count=1.
REQ-030 Armed, io read 0xA3 from port 0x0010 then pop -> tr_data {10,0x0010,0xA3}, tr_empty=1 after pop.
REQ-031 DEPTH=16, 17 mem reads without pop -> tr_full=1, overflow=1, 16 entries retained, first is oldest.
REQ-032 bp_addr[1]=0xFFFF, bp_en=2'b10, mem read 0xFFFF -> hit=1, hit_index=1, halt_req=1 next cycle; subsequent cycles not captured (STOP_ON_HIT=1).
REQ-033 Full FIFO, simultaneous capture and pop -> tr_count stays 16, overflow stays 0.
REQ-034 reset_n low during rd_n low, then release -> no entry, all outputs at reset values; clear after hit -> DISARMED, hit=0.
